// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing constants, the helper
// that derives a total period from its four segments, and the counter width.
// Used by the sync generator and by downstream pixel-generation logic.
package vga_pkg;

    localparam int unsigned CountWidth = 10;

    // Total period of one axis: visible + front porch + sync + back porch.
    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

    localparam int unsigned HVisibleDef = 640;
    localparam int unsigned HFrontDef   = 16;
    localparam int unsigned HSyncDef    = 96;
    localparam int unsigned HBackDef    = 48;
    localparam int unsigned HTotalDef   = axis_total(HVisibleDef, HFrontDef, HSyncDef, HBackDef);

    localparam int unsigned VVisibleDef = 480;
    localparam int unsigned VFrontDef   = 10;
    localparam int unsigned VSyncDef    = 2;
    localparam int unsigned VBackDef    = 33;
    localparam int unsigned VTotalDef   = axis_total(VVisibleDef, VFrontDef, VSyncDef, VBackDef);

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around counter for one VGA axis.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset; loads Total-1 so the first
//             enabled step lands on 0
//   en_i    - advance by one this cycle
//   count_o - registered count, 0..Total-1
//   next_o  - value count_o takes at the next clock edge
//   wrap_o  - high when this enabled step wraps Total-1 -> 0
module vga_axis_counter #(
    parameter int unsigned Total = 800,
    parameter int unsigned Width = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [Width-1:0] count_o,
    output logic [Width-1:0] next_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] Last = Width'(Total - 1);

    logic [Width-1:0] count_q, count_d;
    logic             at_last;

    always_comb begin
        at_last = (count_q == Last);
        wrap_o  = en_i && at_last;
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= Last;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign next_o  = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator. Advances a pixel position on each rising edge of the
// divided pixel clock (sampled as data in the clk domain) and produces
// registered sync/blanking outputs aligned with the counters.
// Ports:
//   clk         - system clock
//   reset       - synchronous active-high reset
//   divided_clk - pixel-rate square wave, sampled as data
//   pixel_tick  - one-cycle strobe when a new pixel is presented
//   hsync/vsync - active-low sync pulses
//   video_on    - current pixel lies in the visible region
//   pixel_x/y   - current horizontal / vertical position
//   frame_start - one-cycle pulse when the position becomes (0,0)
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = HVisibleDef,
    parameter int unsigned H_FRONT   = HFrontDef,
    parameter int unsigned H_SYNC    = HSyncDef,
    parameter int unsigned H_BACK    = HBackDef,
    parameter int unsigned V_VISIBLE = VVisibleDef,
    parameter int unsigned V_FRONT   = VFrontDef,
    parameter int unsigned V_SYNC    = VSyncDef,
    parameter int unsigned V_BACK    = VBackDef
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  divided_clk,
    output logic                  pixel_tick,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  video_on,
    output logic [CountWidth-1:0] pixel_x,
    output logic [CountWidth-1:0] pixel_y,
    output logic                  frame_start
);

    localparam int unsigned W      = CountWidth;
    localparam int unsigned HTotal = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned VTotal = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [W-1:0] HVis       = W'(H_VISIBLE);
    localparam logic [W-1:0] HSyncFirst = W'(H_VISIBLE + H_FRONT);
    localparam logic [W-1:0] HSyncLast  = W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [W-1:0] VVis       = W'(V_VISIBLE);
    localparam logic [W-1:0] VSyncFirst = W'(V_VISIBLE + V_FRONT);
    localparam logic [W-1:0] VSyncLast  = W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic         prev_q;
    logic         advance;
    logic [W-1:0] x_next, y_next;
    logic         x_wrap, y_wrap;
    logic         hsync_d, vsync_d, video_on_d;
    logic         pixel_tick_q, hsync_q, vsync_q, video_on_q, frame_start_q;

    // prev_q resets high so a divided_clk held high across reset release
    // does not look like a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= divided_clk;
        end
    end

    assign advance = divided_clk && !prev_q;

    vga_axis_counter #(
        .Total (HTotal),
        .Width (W)
    ) u_h_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (advance),
        .count_o (pixel_x),
        .next_o  (x_next),
        .wrap_o  (x_wrap)
    );

    vga_axis_counter #(
        .Total (VTotal),
        .Width (W)
    ) u_v_counter (
        .clk     (clk),
        .reset   (reset),
        .en_i    (x_wrap),
        .count_o (pixel_y),
        .next_o  (y_next),
        .wrap_o  (y_wrap)
    );

    // Decode from the next counter values so the registered outputs change
    // on the same edge as the counters.
    always_comb begin
        hsync_d    = !((x_next >= HSyncFirst) && (x_next <= HSyncLast));
        vsync_d    = !((y_next >= VSyncFirst) && (y_next <= VSyncLast));
        video_on_d = (x_next < HVis) && (y_next < VVis);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_tick_q  <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_tick_q  <= advance;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            // Vertical wrap only happens when both axes wrap, i.e. on (0,0).
            frame_start_q <= y_wrap;
        end
    end

    assign pixel_tick  = pixel_tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen. Horizontal timing uses the defaults;
// vertical timing is shortened so a whole frame fits in a short run.
module tb_vga_sync_gen;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 16, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int NPIX = HT * VT;

    logic       clk = 1'b0;
    logic       reset;
    logic       divided_clk;
    logic       pixel_tick, hsync, vsync, video_on, frame_start;
    logic [9:0] pixel_x, pixel_y;

    int total = 0;
    int bad   = 0;

    // Reference model: linear pixel index within the frame.
    int   p;
    logic mprev;
    logic mtick, mfs;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .divided_clk (divided_clk),
        .pixel_tick  (pixel_tick),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mx();
        return p % HT;
    endfunction

    function automatic int my();
        return p / HT;
    endfunction

    // One clk cycle: drive inputs, advance the model, compare all outputs.
    task automatic step(input logic dc, input logic rst);
        logic adv;
        int   x, y;
        @(negedge clk);
        divided_clk = dc;
        reset       = rst;
        @(posedge clk);
        if (rst) begin
            p     = NPIX - 1;
            mprev = 1'b1;
            mtick = 1'b0;
            mfs   = 1'b0;
        end else begin
            adv   = dc && !mprev;
            mprev = dc;
            mtick = adv;
            if (adv) p = (p + 1) % NPIX;
            mfs = adv && (p == 0);
        end
        #1;
        x = mx();
        y = my();
        chk("pixel_x", int'(pixel_x), x);
        chk("pixel_y", int'(pixel_y), y);
        chk("hsync", int'(hsync), (x >= HV + HF && x < HV + HF + HS) ? 0 : 1);
        chk("vsync", int'(vsync), (y >= VV + VF && y < VV + VF + VS) ? 0 : 1);
        chk("video_on", int'(video_on), (x < HV && y < VV) ? 1 : 0);
        chk("pixel_tick", int'(pixel_tick), int'(mtick));
        chk("frame_start", int'(frame_start), int'(mfs));
    endtask

    initial begin
        logic dc;
        int   ticks, vis, vlow, hlow, cyc, got;

        divided_clk = 1'b1;
        reset       = 1'b1;
        p = NPIX - 1; mprev = 1'b1; mtick = 1'b0; mfs = 1'b0;

        // Reset with divided_clk high, then hold it high across release.
        repeat (5) step(1'b1, 1'b1);
        chk("reset_x", int'(pixel_x), HT - 1);
        chk("reset_y", int'(pixel_y), VT - 1);
        ticks = 0;
        repeat (95) begin
            step(1'b1, 1'b0);
            if (pixel_tick) ticks++;
        end
        chk("hold_ticks", ticks, 0);
        chk("hold_x", int'(pixel_x), HT - 1);

        // divided_clk toggling every 5 clk: first tick is pixel (0,0).
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("first_tick", int'(pixel_tick), 1);
        chk("first_x", int'(pixel_x), 0);
        chk("first_y", int'(pixel_y), 0);
        chk("first_fs", int'(frame_start), 1);
        chk("first_video", int'(video_on), 1);
        chk("first_hsync", int'(hsync), 1);
        chk("first_vsync", int'(vsync), 1);
        repeat (4) step(1'b1, 1'b0);

        // Full frame with randomly stretched divided_clk phases.
        dc = 1'b1;
        ticks = 1; vis = 1; vlow = 0; hlow = 0; got = 0; cyc = 0;
        while (!got && cyc < 60000) begin
            if ($urandom_range(7) != 0) dc = ~dc;
            step(dc, 1'b0);
            cyc++;
            if (pixel_tick) begin
                if (frame_start) begin
                    got = 1;
                end else begin
                    ticks++;
                    if (video_on) vis++;
                    if (!vsync) vlow++;
                    if (!hsync) hlow++;
                end
            end
        end
        chk("frame_seen", got, 1);
        chk("frame_ticks", ticks, NPIX);
        chk("frame_visible", vis, HV * VV);
        chk("frame_vsync_low", vlow, VS * HT);
        chk("frame_hsync_low", hlow, HS * VT);

        // Reach x=300, then assert reset on the cycle of an advance.
        cyc = 0;
        while (!(mtick && mx() == 300) && cyc < 5000) begin
            if ($urandom_range(3) != 0) dc = ~dc;
            step(dc, 1'b0);
            cyc++;
        end
        chk("reach_300", mx(), 300);
        if (dc) step(1'b0, 1'b0);
        chk("pre_reset_x", int'(pixel_x), 300);
        step(1'b1, 1'b1);
        chk("mid_reset_x", int'(pixel_x), HT - 1);
        chk("mid_reset_tick", int'(pixel_tick), 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("after_reset_x", int'(pixel_x), 0);
        chk("after_reset_y", int'(pixel_y), 0);
        chk("after_reset_fs", int'(frame_start), 1);
        chk("after_reset_video", int'(video_on), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
